// File: rtl/cnn_acc_pkg.sv
// -----------------------------------------------------------------------------
// cnn_acc_pkg
// Shared definitions for the conv accumulate / ReLU stage.
//   - state_e      : window FSM states (accepting taps, post-processing, holding)
//   - *_DEF        : default widths / counts used as module parameter defaults
//   - ROUND_K      : half-LSB rounding constant for the default SHIFT
//   - ACT_MAX      : largest positive activation for the default OUT_W
// -----------------------------------------------------------------------------
package cnn_acc_pkg;

   typedef enum logic [1:0] {
      S_ACC  = 2'd0,
      S_POST = 2'd1,
      S_OUT  = 2'd2
   } state_e;

   localparam int PROD_W_DEF = 32'd22;
   localparam int ACC_W_DEF  = 32'd32;
   localparam int BIAS_W_DEF = 32'd14;
   localparam int OUT_W_DEF  = 32'd14;
   localparam int SHIFT_DEF  = 32'd6;
   localparam int N_TAPS_DEF = 32'd9;

   localparam int ROUND_K = 32'd1 << (SHIFT_DEF - 32'd1);
   localparam int ACT_MAX = (32'd1 << (OUT_W_DEF - 32'd1)) - 32'd1;

endpackage

// File: rtl/cnn_acc_post.sv
// -----------------------------------------------------------------------------
// cnn_acc_post
// Combinational post-processing of a finished window sum:
// round half up, drop SHIFT fraction bits (arithmetic), ReLU, saturate to
// the positive range of the OUT_W activation format.
// Ports:
//   acc_i  in  ACC_W  signed window sum
//   act_o  out OUT_W  activation in [0, 2^(OUT_W-1)-1]
// -----------------------------------------------------------------------------
module cnn_acc_post
   import cnn_acc_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int OUT_W = OUT_W_DEF,
   parameter int SHIFT = SHIFT_DEF
) (
   input  logic [ACC_W-1:0] acc_i,
   output logic [OUT_W-1:0] act_o
);

   // One guard bit so adding the rounding constant to a sum near the
   // positive limit cannot wrap negative.
   localparam logic signed [ACC_W:0] ROUND_K_L = (ACC_W+1)'(1) <<< (SHIFT - 1);
   localparam logic signed [ACC_W:0] ACT_MAX_L =
      ((ACC_W+1)'(1) <<< (OUT_W - 1)) - (ACC_W+1)'(1);

   logic signed [ACC_W:0] sum_s;
   logic signed [ACC_W:0] rnd_s;

   assign sum_s = $signed({acc_i[ACC_W-1], acc_i}) + ROUND_K_L;
   assign rnd_s = sum_s >>> SHIFT;

   // ReLU and positive saturation of the rounded value.
   always_comb begin
      act_o = '0;
      if (rnd_s[ACC_W]) begin
         act_o = '0;
      end else if (rnd_s > ACT_MAX_L) begin
         act_o = ACT_MAX_L[OUT_W-1:0];
      end else begin
         act_o = rnd_s[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/cnn_conv_acc_relu.sv
// -----------------------------------------------------------------------------
// cnn_conv_acc_relu
// Sums N_TAPS signed products plus a bias (aligned to the product fraction)
// per window, then rounds, applies ReLU and saturates the result and offers
// it downstream over valid/ready.
// Ports:
//   ap_clk     in   1       clock
//   ap_rst     in   1       synchronous active-high reset
//   in_valid   in   1       product beat valid
//   in_ready   out  1       stage accepting products (high only in S_ACC)
//   in_prod    in   PROD_W  signed product
//   in_bias    in   BIAS_W  signed bias, sampled on tap 0 only
//   out_valid  out  1       activation valid
//   out_ready  in   1       downstream accepts activation
//   out_data   out  OUT_W   activation
// -----------------------------------------------------------------------------
module cnn_conv_acc_relu
   import cnn_acc_pkg::*;
#(
   parameter int PROD_W = PROD_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int BIAS_W = BIAS_W_DEF,
   parameter int OUT_W  = OUT_W_DEF,
   parameter int SHIFT  = SHIFT_DEF,
   parameter int N_TAPS = N_TAPS_DEF
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic [BIAS_W-1:0] in_bias,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data
);

   localparam int CNT_W = $clog2(N_TAPS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TAPS - 1);

   state_e             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic [ACC_W-1:0]   acc_q,       acc_d;
   logic               out_valid_q, out_valid_d;
   logic [OUT_W-1:0]   out_data_q,  out_data_d;

   logic [ACC_W-1:0]   prod_ext_s;
   logic [ACC_W-1:0]   bias_ext_s;
   logic [ACC_W-1:0]   bias_aln_s;
   logic [OUT_W-1:0]   post_s;
   logic               xfer_s;

   assign prod_ext_s = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
   assign bias_ext_s = {{(ACC_W-BIAS_W){in_bias[BIAS_W-1]}}, in_bias};
   // Bias is in activation format; shift it up to the product's fraction.
   assign bias_aln_s = bias_ext_s << SHIFT;

   // in_ready depends only on the state register, never on out_ready.
   assign in_ready  = (state_q == S_ACC);
   assign xfer_s    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   cnn_acc_post #(
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_post (
      .acc_i (acc_q),
      .act_o (post_s)
   );

   // Window FSM next-state, tap accumulation and output register updates.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      case (state_q)
         S_ACC: begin
            if (xfer_s) begin
               if (cnt_q == '0) begin
                  acc_d = bias_aln_s + prod_ext_s;
               end else begin
                  acc_d = acc_q + prod_ext_s;
               end
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = S_POST;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               acc_d = acc_q;
               cnt_d = cnt_q;
            end
         end
         S_POST: begin
            out_data_d  = post_s;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_ACC;
            end else begin
               out_valid_d = out_valid_q;
               state_d     = S_OUT;
            end
         end
         default: begin
            state_d     = S_ACC;
            cnt_d       = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q     <= S_ACC;
         cnt_q       <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

endmodule

// File: tb/tb_cnn_conv_acc_relu.sv
// -----------------------------------------------------------------------------
// tb_cnn_conv_acc_relu
// Directed self-checking bench for cnn_conv_acc_relu with default parameters
// (N_TAPS=9, SHIFT=6, OUT_W=14). Expected activations are hand computed.
// -----------------------------------------------------------------------------
module tb_cnn_conv_acc_relu;

   logic               ap_clk = 1'b0;
   logic               ap_rst;
   logic               in_valid;
   logic               in_ready;
   logic signed [21:0] in_prod;
   logic signed [13:0] in_bias;
   logic               out_valid;
   logic               out_ready;
   logic [13:0]        out_data;

   int errors = 0;
   int checks = 0;

   cnn_conv_acc_relu dut (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_prod   (in_prod),
      .in_bias   (in_bias),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; leave 1 time unit after the edge for sampling/driving.
   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // One accepted beat (in_ready is high in S_ACC), then idle with junk data.
   task automatic beat(input logic signed [21:0] p, input logic signed [13:0] b);
      in_valid = 1'b1;
      in_prod  = p;
      in_bias  = b;
      tick();
      in_valid = 1'b0;
      in_prod  = 22'sd12345;
      in_bias  = 14'sd77;
   endtask

   // Full window: tap 0 = p0, taps 1..8 = pn; optional idle cycle between taps.
   task automatic window(input string tag, input logic signed [13:0] b,
                         input logic signed [21:0] p0, input logic signed [21:0] pn,
                         input bit gap, input logic [13:0] exp);
      for (int i = 0; i < 9; i++) begin
         if (gap && i > 0) tick();
         beat((i == 0) ? p0 : pn, b);
      end
      chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_post_ready"}, 32'(in_ready), 32'd0);
      tick();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, 32'(out_data), 32'(exp));
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      tick();
      chk({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_hs_ready"}, 32'(in_ready), 32'd1);
      out_ready = 1'b0;
   endtask

   initial begin
      ap_rst    = 1'b1;
      in_valid  = 1'b0;
      in_prod   = 22'sd0;
      in_bias   = 14'sd0;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data",  32'(out_data),  32'd0);
      chk("rst_ready", 32'(in_ready),  32'd1);
      ap_rst = 1'b0;

      // 9*64 = 576 -> (576+32)>>>6 = 9
      window("basic", 14'sd0, 22'sd64, 22'sd64, 1'b0, 14'd9);
      handshake("basic");

      // (32+32)>>>6 = 1 ; (31+32)>>>6 = 0 ; (3<<6 + 32)>>>6 = 3
      window("rnd32", 14'sd0, 22'sd32, 22'sd0, 1'b0, 14'd1);
      handshake("rnd32");
      window("rnd31", 14'sd0, 22'sd31, 22'sd0, 1'b0, 14'd0);
      handshake("rnd31");
      out_ready = 1'b1;   // ready asserted before valid
      window("bias3", 14'sd3, 22'sd0, 22'sd0, 1'b0, 14'd3);
      handshake("bias3");

      // -900 -> -14 -> 0 ; 18,000,000 -> 281250 -> 8191 ; -8192 bias -> 0
      window("neg",  14'sd0, -22'sd100, -22'sd100, 1'b0, 14'd0);
      handshake("neg");
      window("sat",  14'sd0, 22'sd2000000, 22'sd2000000, 1'b0, 14'd8191);
      handshake("sat");
      window("bmin", -14'sd8192, 22'sd0, 22'sd0, 1'b0, 14'd0);
      handshake("bmin");

      // Backpressure: beats offered while holding must not be accepted.
      window("bp", 14'sd0, 22'sd64, 22'sd64, 1'b0, 14'd9);
      in_valid = 1'b1;
      in_prod  = 22'sd1000;
      in_bias  = 14'sd50;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold_data",  32'(out_data),  32'd9);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
         chk("bp_hold_ready", 32'(in_ready),  32'd0);
      end
      in_valid = 1'b0;
      handshake("bp");
      // (5<<6 + 32)>>>6 = 5
      window("bp_next", 14'sd5, 22'sd0, 22'sd0, 1'b0, 14'd5);
      handshake("bp_next");

      // Gapped input still gives 9.
      window("gap", 14'sd0, 22'sd64, 22'sd64, 1'b1, 14'd9);
      handshake("gap");

      // Reset mid-window discards the partial sum and the bias.
      for (int i = 0; i < 4; i++) beat(22'sd1000, 14'sd100);
      ap_rst   = 1'b1;
      in_valid = 1'b1;
      in_prod  = 22'sd1000;
      tick();
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_data",  32'(out_data),  32'd0);
      chk("mrst_ready", 32'(in_ready),  32'd1);
      ap_rst   = 1'b0;
      in_valid = 1'b0;
      window("after_rst", 14'sd0, 22'sd64, 22'sd64, 1'b0, 14'd9);
      handshake("after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
